// File: rtl/mem_wb_lbr_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_lbr_stage_if
//  Description : Bundle between the memory stage / hazard unit and the
//                memory-to-writeback stage.
//                master : upstream pipeline (drives instruction, memory and
//                         LBR data, and control; observes write-back and stall)
//                slave  : mem_wb_lbr_stage
//  Signals     : stall_in, flush, in_valid, in_load, opSel, regWrite_in,
//                write_sel_in, ALU_Result, load_data, load_valid, lbr_data,
//                report  (master -> slave)
//                write_enable, write_sel, write_data, mem_stall,
//                load_timeout_err, wb_count  (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_wb_lbr_stage_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_SEL_BITS = 5
);
  logic                    stall_in;
  logic                    flush;
  logic                    in_valid;
  logic                    in_load;
  logic [1:0]              opSel;
  logic                    regWrite_in;
  logic [REG_SEL_BITS-1:0] write_sel_in;
  logic [DATA_WIDTH-1:0]   ALU_Result;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    load_valid;
  logic [DATA_WIDTH-1:0]   lbr_data;
  logic                    report;

  logic                    write_enable;
  logic [REG_SEL_BITS-1:0] write_sel;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    mem_stall;
  logic                    load_timeout_err;
  logic [31:0]             wb_count;

  modport master (
    output stall_in, flush, in_valid, in_load, opSel, regWrite_in,
           write_sel_in, ALU_Result, load_data, load_valid, lbr_data, report,
    input  write_enable, write_sel, write_data, mem_stall, load_timeout_err,
           wb_count
  );

  modport slave (
    input  stall_in, flush, in_valid, in_load, opSel, regWrite_in,
           write_sel_in, ALU_Result, load_data, load_valid, lbr_data, report,
    output write_enable, write_sel, write_data, mem_stall, load_timeout_err,
           wb_count
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_lbr_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_lbr_stage
//  Description : Memory-to-writeback stage. Selects the write-back source
//                (ALU result, load data or LBR record), registers the
//                register-file write, stalls upstream until load data is
//                valid, buffers load data that arrives under a global stall
//                and drops loads that wait longer than LOAD_TIMEOUT cycles.
//  Ports       : clock  - system clock
//                reset  - synchronous, active-low reset
//                bus    - mem_wb_lbr_stage_if.slave (all datapath/control)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wb_lbr_stage #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int REG_SEL_BITS = 5,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_wb_lbr_stage_if.slave    bus
);

  localparam int                CNT_W       = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(LOAD_TIMEOUT);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        wait_cnt_q;
  logic [DATA_WIDTH-1:0]   load_buf_q;
  logic                    buf_full_q;
  logic                    write_enable_q;
  logic [REG_SEL_BITS-1:0] write_sel_q;
  logic [DATA_WIDTH-1:0]   write_data_q;
  logic                    timeout_err_q;
  logic [31:0]             wb_count_q;

  logic                    have_data;
  logic                    drop;
  logic                    mem_stall;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   write_data_d;

  // Report tracing is a simulation feature; the synthesizable stage only
  // sinks the request and the core id.
  logic                    w_unused_report;
  assign w_unused_report = bus.report | (CORE != 0);

  // Buffered data counts as arrived, so a load whose data landed during a
  // global stall never re-requests mem_stall.
  assign have_data = bus.load_valid | buf_full_q;
  assign drop      = (state_q == WAIT_LOAD) && (wait_cnt_q == TIMEOUT_CNT) && !have_data;
  assign mem_stall = bus.in_valid & bus.in_load & !have_data & !drop & !bus.flush;
  assign accept    = bus.in_valid & !bus.stall_in & !bus.flush & !mem_stall;

  always_comb begin
    write_data_d = bus.ALU_Result;
    if (drop) begin
      write_data_d = '0;
    end else begin
      case (bus.opSel)
        2'b01:   write_data_d = buf_full_q ? load_buf_q : bus.load_data;
        2'b10:   write_data_d = bus.lbr_data;
        default: write_data_d = bus.ALU_Result;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      wait_cnt_q     <= '0;
      load_buf_q     <= '0;
      buf_full_q     <= 1'b0;
      write_enable_q <= 1'b0;
      write_sel_q    <= '0;
      write_data_q   <= '0;
      timeout_err_q  <= 1'b0;
      wb_count_q     <= '0;
    end else if (bus.flush) begin
      // Flush wins over everything: no write, no count, forget any wait.
      state_q        <= IDLE;
      wait_cnt_q     <= '0;
      buf_full_q     <= 1'b0;
      write_enable_q <= 1'b0;
    end else begin
      // Write-back register: only an accepted instruction writes, so a held
      // instruction under stall never produces a second write.
      if (accept) begin
        write_enable_q <= bus.regWrite_in && (bus.write_sel_in != '0) && !drop;
        write_sel_q    <= bus.write_sel_in;
        write_data_q   <= write_data_d;
        wb_count_q     <= wb_count_q + 32'd1;
      end else begin
        write_enable_q <= 1'b0;
      end

      // Load-data buffer: capture data that arrives while the pipe is frozen.
      if (accept) begin
        buf_full_q <= 1'b0;
      end else if (bus.stall_in && bus.in_load && bus.load_valid) begin
        load_buf_q <= bus.load_data;
        buf_full_q <= 1'b1;
      end

      if (drop) begin
        timeout_err_q <= 1'b1;
      end

      // Load-wait FSM; the counter saturates at LOAD_TIMEOUT because
      // mem_stall is forced low in the drop cycle.
      case (state_q)
        IDLE: begin
          if (mem_stall) begin
            state_q    <= WAIT_LOAD;
            wait_cnt_q <= CNT_W'(1);
          end
        end
        WAIT_LOAD: begin
          if (accept || !bus.in_valid) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else if (mem_stall) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.write_enable     = write_enable_q;
  assign bus.write_sel        = write_sel_q;
  assign bus.write_data       = write_data_q;
  assign bus.mem_stall        = mem_stall;
  assign bus.load_timeout_err = timeout_err_q;
  assign bus.wb_count         = wb_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_lbr_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_lbr_stage
//  Description : Directed self-checking bench for mem_wb_lbr_stage
//                (LOAD_TIMEOUT = 4). Inputs change 1 time unit after the
//                rising edge; outputs are sampled at the same point.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_wb_lbr_stage;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] exp_count;

  mem_wb_lbr_stage_if #(.DATA_WIDTH(32), .REG_SEL_BITS(5)) bus ();

  mem_wb_lbr_stage #(
    .CORE(0), .DATA_WIDTH(32), .REG_SEL_BITS(5), .LOAD_TIMEOUT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall_in = 0; bus.flush = 0; bus.in_valid = 0; bus.in_load = 0;
    bus.opSel = 2'b00; bus.regWrite_in = 0; bus.write_sel_in = '0;
    bus.ALU_Result = '0; bus.load_data = '0; bus.load_valid = 0;
    bus.lbr_data = '0; bus.report = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    bus.stall_in = 1; bus.flush = 1; bus.in_valid = 0; bus.in_load = 1;
    bus.opSel = 2'b01; bus.regWrite_in = 1; bus.write_sel_in = 5'd7;
    bus.ALU_Result = 32'hFFFF_FFFF; bus.load_data = 32'hAAAA_5555;
    bus.load_valid = 1; bus.lbr_data = 32'h1234_5678; bus.report = 1;
    step(); step();
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.write_enable); end
    checks++; if (bus.write_sel !== 5'd0) begin failures++; $display("FAIL reset_sel got=%h exp=0", bus.write_sel); end
    checks++; if (bus.write_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.write_data); end
    checks++; if (bus.mem_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.mem_stall); end
    checks++; if (bus.load_timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.load_timeout_err); end
    checks++; if (bus.wb_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", bus.wb_count); end
    idle_inputs();
    reset = 1;
    step();
    exp_count = 0;
  endtask

  task automatic test_alu();
    bus.in_valid = 1; bus.opSel = 2'b00; bus.regWrite_in = 1;
    bus.write_sel_in = 5'd5; bus.ALU_Result = 32'h1234;
    #1;
    checks++; if (bus.mem_stall !== 1'b0) begin failures++; $display("FAIL alu_nostall got=%b exp=0", bus.mem_stall); end
    step(); exp_count++;
    checks++; if (bus.write_enable !== 1'b1) begin failures++; $display("FAIL alu_we got=%b exp=1", bus.write_enable); end
    checks++; if (bus.write_sel !== 5'd5) begin failures++; $display("FAIL alu_sel got=%h exp=5", bus.write_sel); end
    checks++; if (bus.write_data !== 32'h1234) begin failures++; $display("FAIL alu_data got=%h exp=1234", bus.write_data); end
    checks++; if (bus.wb_count !== exp_count) begin failures++; $display("FAIL alu_count got=%h exp=%h", bus.wb_count, exp_count); end
    // Destination r0 is never written, but the instruction still retires.
    bus.write_sel_in = 5'd0; bus.ALU_Result = 32'h5678; bus.opSel = 2'b11;
    step(); exp_count++;
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL alu_r0_we got=%b exp=0", bus.write_enable); end
    checks++; if (bus.write_data !== 32'h5678) begin failures++; $display("FAIL alu_op11_data got=%h exp=5678", bus.write_data); end
    checks++; if (bus.wb_count !== exp_count) begin failures++; $display("FAIL alu_r0_count got=%h exp=%h", bus.wb_count, exp_count); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1; bus.regWrite_in = 1; bus.write_sel_in = 5'd2;
    bus.ALU_Result = 32'h0000_0AAA;
    step(); exp_count++;
    // Held instruction under stall must not write again.
    bus.stall_in = 1; bus.write_sel_in = 5'd6; bus.ALU_Result = 32'h0000_0BBB;
    step();
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL b2b_stall_we got=%b exp=0", bus.write_enable); end
    checks++; if (bus.write_data !== 32'h0AAA) begin failures++; $display("FAIL b2b_hold_data got=%h exp=0aaa", bus.write_data); end
    checks++; if (bus.wb_count !== exp_count) begin failures++; $display("FAIL b2b_stall_count got=%h exp=%h", bus.wb_count, exp_count); end
    bus.stall_in = 0;
    step(); exp_count++;
    checks++; if (bus.write_enable !== 1'b1 || bus.write_data !== 32'h0BBB || bus.write_sel !== 5'd6) begin
      failures++; $display("FAIL b2b_release got=%b/%h/%h exp=1/06/0bbb", bus.write_enable, bus.write_sel, bus.write_data); end
    idle_inputs();
    step();
  endtask

  task automatic test_load_latency();
    bus.in_valid = 1; bus.in_load = 1; bus.opSel = 2'b01; bus.regWrite_in = 1;
    bus.write_sel_in = 5'd3; bus.ALU_Result = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.mem_stall !== 1'b1) begin failures++; $display("FAIL lat_stall_%0d got=%b exp=1", i, bus.mem_stall); end
      step();
    end
    bus.load_valid = 1; bus.load_data = 32'hCAFE;
    #1;
    checks++; if (bus.mem_stall !== 1'b0) begin failures++; $display("FAIL lat_release got=%b exp=0", bus.mem_stall); end
    step(); exp_count++;
    checks++; if (bus.write_enable !== 1'b1 || bus.write_sel !== 5'd3) begin
      failures++; $display("FAIL lat_we got=%b/%h exp=1/03", bus.write_enable, bus.write_sel); end
    checks++; if (bus.write_data !== 32'hCAFE) begin failures++; $display("FAIL lat_data got=%h exp=cafe", bus.write_data); end
    checks++; if (bus.wb_count !== exp_count) begin failures++; $display("FAIL lat_count got=%h exp=%h", bus.wb_count, exp_count); end
    idle_inputs();
    step();
  endtask

  task automatic test_buffered_load();
    bus.in_valid = 1; bus.in_load = 1; bus.opSel = 2'b01; bus.regWrite_in = 1;
    bus.write_sel_in = 5'd9; bus.stall_in = 1;
    #1;
    checks++; if (bus.mem_stall !== 1'b1) begin failures++; $display("FAIL buf_pre_stall got=%b exp=1", bus.mem_stall); end
    step();
    bus.load_valid = 1; bus.load_data = 32'hBEEF;
    step();
    bus.load_valid = 0; bus.load_data = 32'h1111;
    #1;
    checks++; if (bus.mem_stall !== 1'b0) begin failures++; $display("FAIL buf_post_pulse_stall got=%b exp=0", bus.mem_stall); end
    step();
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL buf_held_we got=%b exp=0", bus.write_enable); end
    bus.stall_in = 0;
    #1;
    checks++; if (bus.mem_stall !== 1'b0) begin failures++; $display("FAIL buf_release_stall got=%b exp=0", bus.mem_stall); end
    step(); exp_count++;
    checks++; if (bus.write_enable !== 1'b1 || bus.write_data !== 32'hBEEF) begin
      failures++; $display("FAIL buf_data got=%b/%h exp=1/beef", bus.write_enable, bus.write_data); end
    checks++; if (bus.wb_count !== exp_count) begin failures++; $display("FAIL buf_count got=%h exp=%h", bus.wb_count, exp_count); end
    idle_inputs();
    step();
  endtask

  task automatic test_timeout();
    checks++; if (bus.load_timeout_err !== 1'b0) begin failures++; $display("FAIL to_err_before got=%b exp=0", bus.load_timeout_err); end
    bus.in_valid = 1; bus.in_load = 1; bus.opSel = 2'b01; bus.regWrite_in = 1;
    bus.write_sel_in = 5'd4; bus.load_data = 32'h9999;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.mem_stall !== 1'b1) begin failures++; $display("FAIL to_stall_%0d got=%b exp=1", i, bus.mem_stall); end
      step();
    end
    #1;
    checks++; if (bus.mem_stall !== 1'b0) begin failures++; $display("FAIL to_drop_stall got=%b exp=0", bus.mem_stall); end
    step(); exp_count++;
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL to_we got=%b exp=0", bus.write_enable); end
    checks++; if (bus.write_data !== 32'd0) begin failures++; $display("FAIL to_data got=%h exp=0", bus.write_data); end
    checks++; if (bus.load_timeout_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", bus.load_timeout_err); end
    checks++; if (bus.wb_count !== exp_count) begin failures++; $display("FAIL to_count got=%h exp=%h", bus.wb_count, exp_count); end
    idle_inputs();
    step(); step(); step();
    checks++; if (bus.load_timeout_err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", bus.load_timeout_err); end
  endtask

  task automatic test_lbr_flush();
    bus.in_valid = 1; bus.opSel = 2'b10; bus.regWrite_in = 1;
    bus.write_sel_in = 5'd7; bus.lbr_data = 32'h8000_1000; bus.ALU_Result = 32'h4242;
    step(); exp_count++;
    checks++; if (bus.write_enable !== 1'b1 || bus.write_data !== 32'h8000_1000) begin
      failures++; $display("FAIL lbr_data got=%b/%h exp=1/80001000", bus.write_enable, bus.write_data); end
    bus.in_load = 1; bus.opSel = 2'b01; bus.write_sel_in = 5'd8;
    step(); step(); step();
    bus.flush = 1;
    #1;
    checks++; if (bus.mem_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", bus.mem_stall); end
    step();
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL flush_we got=%b exp=0", bus.write_enable); end
    checks++; if (bus.wb_count !== exp_count) begin failures++; $display("FAIL flush_count got=%h exp=%h", bus.wb_count, exp_count); end
    // A fresh load right after flush must get the full timeout window.
    bus.flush = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.mem_stall !== 1'b1) begin failures++; $display("FAIL post_flush_stall_%0d got=%b exp=1", i, bus.mem_stall); end
      step();
    end
    bus.load_valid = 1; bus.load_data = 32'h77;
    step(); exp_count++;
    checks++; if (bus.write_enable !== 1'b1 || bus.write_data !== 32'h77 || bus.write_sel !== 5'd8) begin
      failures++; $display("FAIL post_flush_load got=%b/%h/%h exp=1/08/77", bus.write_enable, bus.write_sel, bus.write_data); end
    checks++; if (bus.wb_count !== exp_count) begin failures++; $display("FAIL post_flush_count got=%h exp=%h", bus.wb_count, exp_count); end
    checks++; if (bus.load_timeout_err !== 1'b1) begin failures++; $display("FAIL err_still_set got=%b exp=1", bus.load_timeout_err); end
    idle_inputs();
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_count = 0;
    reset = 0;
    idle_inputs();
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_latency();
    test_buffered_load();
    test_timeout();
    test_lbr_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
